// File: rtl/esl_clk_check_pkg.sv
// Shared types and default sizing for the clock-check counter and its frequency comparator.
package esl_clk_check_pkg;

    localparam int unsigned BIT_WD_DEF      = 24;
    localparam int unsigned SYNC_STAGES_DEF = 2;

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        CAPTURE
    } state_e;

endpackage

// File: rtl/esl_clk_check_cut_cnt_if.sv
// Window-enable request and captured-count result bundle between the window source and the counter.
interface esl_clk_check_cut_cnt_if
    import esl_clk_check_pkg::*;
#(
    parameter int unsigned BIT_WD = BIT_WD_DEF
);

    logic              window_en;
    logic [BIT_WD:0]   cut_count_end_val;
    logic              end_val_valid;
    logic              count_sat;
    logic              busy;

    modport master (
        output window_en,
        input  cut_count_end_val,
        input  end_val_valid,
        input  count_sat,
        input  busy
    );

    modport slave (
        input  window_en,
        output cut_count_end_val,
        output end_val_valid,
        output count_sat,
        output busy
    );

endinterface

// File: rtl/esl_clk_check_sync.sv
// Multi-flop synchroniser bringing the reference-domain window level into cut_clk.
module esl_clk_check_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic cut_clk,
    input  logic reset,
    input  logic async_in,
    output logic sync_out
);

    (* preserve, async_reg = "true" *) logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge cut_clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/esl_clk_check_cut_cnt.sv
// Counts cut_clk cycles while the synchronised window is open and captures the total at window end.
module esl_clk_check_cut_cnt
    import esl_clk_check_pkg::*;
#(
    parameter int unsigned BIT_WD      = BIT_WD_DEF,
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic                    cut_clk,
    input  logic                    reset,
    esl_clk_check_cut_cnt_if.slave  bus
);

    typedef logic [BIT_WD:0] cnt_t;

    localparam cnt_t CNT_MAX = {(BIT_WD + 1){1'b1}};

    logic   win_s;
    state_e state_q, state_d;
    cnt_t   cnt_q, cnt_d;
    logic   sat_q, sat_d;
    cnt_t   end_val_q, end_val_d;
    logic   count_sat_q, count_sat_d;
    logic   valid_q, valid_d;

    esl_clk_check_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .cut_clk  (cut_clk),
        .reset    (reset),
        .async_in (bus.window_en),
        .sync_out (win_s)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sat_d       = sat_q;
        end_val_d   = end_val_q;
        count_sat_d = count_sat_q;
        valid_d     = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (win_s) begin
                    state_d = COUNT;
                    cnt_d   = cnt_t'(1);
                end
            end
            COUNT: begin
                if (win_s) begin
                    // Hold at all-ones; a further high cycle marks the window as saturated.
                    if (cnt_q == CNT_MAX) begin
                        sat_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + cnt_t'(1);
                    end
                end else begin
                    // Result registers load on entry so the pulse is high during CAPTURE.
                    state_d     = CAPTURE;
                    end_val_d   = cnt_q;
                    count_sat_d = sat_q;
                    valid_d     = 1'b1;
                end
            end
            CAPTURE: begin
                sat_d = 1'b0;
                if (win_s) begin
                    state_d = COUNT;
                    cnt_d   = cnt_t'(1);
                end else begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                sat_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge cut_clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            sat_q       <= 1'b0;
            end_val_q   <= '0;
            count_sat_q <= 1'b0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sat_q       <= sat_d;
            end_val_q   <= end_val_d;
            count_sat_q <= count_sat_d;
            valid_q     <= valid_d;
        end
    end

    assign bus.cut_count_end_val = end_val_q;
    assign bus.end_val_valid     = valid_q;
    assign bus.count_sat         = count_sat_q;
    assign bus.busy              = (state_q == COUNT);

endmodule

// File: tb/tb_esl_clk_check_cut_cnt.sv
// Directed bench for the cut_clk window counter: a default-width and a 3-bit saturating instance.
module tb_esl_clk_check_cut_cnt;

    localparam int unsigned SYNC = 2;

    logic cut_clk = 1'b0;
    logic reset   = 1'b1;

    int total = 0;
    int bad   = 0;

    int          pulses_a = 0;
    int          pulses_b = 0;
    logic [24:0] vals_a[$];
    logic [3:0]  vals_b[$];

    always #5 cut_clk = ~cut_clk;

    esl_clk_check_cut_cnt_if #(.BIT_WD(24)) bus_a ();
    esl_clk_check_cut_cnt_if #(.BIT_WD(3))  bus_b ();

    esl_clk_check_cut_cnt #(
        .BIT_WD      (24),
        .SYNC_STAGES (SYNC)
    ) dut_a (
        .cut_clk (cut_clk),
        .reset   (reset),
        .bus     (bus_a)
    );

    esl_clk_check_cut_cnt #(
        .BIT_WD      (3),
        .SYNC_STAGES (SYNC)
    ) dut_b (
        .cut_clk (cut_clk),
        .reset   (reset),
        .bus     (bus_b)
    );

    // Advance one cycle and sample just after the rising edge; every pulse is seen exactly once.
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge cut_clk);
            #1;
            if (bus_a.end_val_valid === 1'b1) begin
                pulses_a++;
                vals_a.push_back(bus_a.cut_count_end_val);
            end
            if (bus_b.end_val_valid === 1'b1) begin
                pulses_b++;
                vals_b.push_back(bus_b.cut_count_end_val);
            end
        end
    endtask

    task automatic test_reset();
        reset           = 1'b1;
        bus_a.window_en = 1'b0;
        bus_b.window_en = 1'b0;
        tick(3);
        total++; if (bus_a.cut_count_end_val !== 25'd0) begin bad++;
            $display("FAIL reset_end_val: got %0d want 0", bus_a.cut_count_end_val); end
        total++; if (bus_a.end_val_valid !== 1'b0) begin bad++;
            $display("FAIL reset_valid: got %b want 0", bus_a.end_val_valid); end
        total++; if (bus_a.count_sat !== 1'b0) begin bad++;
            $display("FAIL reset_sat: got %b want 0", bus_a.count_sat); end
        total++; if (bus_a.busy !== 1'b0) begin bad++;
            $display("FAIL reset_busy: got %b want 0", bus_a.busy); end
        total++; if (bus_b.cut_count_end_val !== 4'd0) begin bad++;
            $display("FAIL reset_end_val_b: got %0d want 0", bus_b.cut_count_end_val); end
        reset = 1'b0;
        tick(3);
        pulses_a = 0;
        pulses_b = 0;
    endtask

    task automatic test_window_100();
        pulses_a = 0;
        vals_a.delete();
        bus_a.window_en = 1'b1;
        tick(50);
        total++; if (bus_a.busy !== 1'b1) begin bad++;
            $display("FAIL w100_busy: got %b want 1", bus_a.busy); end
        tick(50);
        bus_a.window_en = 1'b0;
        tick(1);
        total++; if (bus_a.end_val_valid !== 1'b0) begin bad++;
            $display("FAIL w100_early1: got %b want 0", bus_a.end_val_valid); end
        tick(1);
        total++; if (bus_a.end_val_valid !== 1'b0) begin bad++;
            $display("FAIL w100_early2: got %b want 0", bus_a.end_val_valid); end
        tick(1);
        total++; if (bus_a.end_val_valid !== 1'b1) begin bad++;
            $display("FAIL w100_latency: got %b want 1", bus_a.end_val_valid); end
        total++; if (bus_a.cut_count_end_val !== 25'd100) begin bad++;
            $display("FAIL w100_value: got %0d want 100", bus_a.cut_count_end_val); end
        total++; if (bus_a.count_sat !== 1'b0) begin bad++;
            $display("FAIL w100_sat: got %b want 0", bus_a.count_sat); end
        tick(10);
        total++; if (pulses_a !== 1) begin bad++;
            $display("FAIL w100_pulses: got %0d want 1", pulses_a); end
        total++; if (bus_a.cut_count_end_val !== 25'd100) begin bad++;
            $display("FAIL w100_hold: got %0d want 100", bus_a.cut_count_end_val); end
        total++; if (bus_a.busy !== 1'b0) begin bad++;
            $display("FAIL w100_idle_busy: got %b want 0", bus_a.busy); end
    endtask

    task automatic test_saturate();
        pulses_b = 0;
        vals_b.delete();
        bus_b.window_en = 1'b1;
        tick(20);
        bus_b.window_en = 1'b0;
        tick(3);
        total++; if (bus_b.cut_count_end_val !== 4'd15) begin bad++;
            $display("FAIL sat_value: got %0d want 15", bus_b.cut_count_end_val); end
        total++; if (bus_b.count_sat !== 1'b1) begin bad++;
            $display("FAIL sat_flag: got %b want 1", bus_b.count_sat); end
        tick(4);
        bus_b.window_en = 1'b1;
        tick(3);
        total++; if (bus_b.count_sat !== 1'b1) begin bad++;
            $display("FAIL sat_hold: got %b want 1", bus_b.count_sat); end
        tick(2);
        bus_b.window_en = 1'b0;
        tick(3);
        total++; if (bus_b.cut_count_end_val !== 4'd5) begin bad++;
            $display("FAIL sat_next_value: got %0d want 5", bus_b.cut_count_end_val); end
        total++; if (bus_b.count_sat !== 1'b0) begin bad++;
            $display("FAIL sat_next_flag: got %b want 0", bus_b.count_sat); end
        tick(5);
        total++; if (pulses_b !== 2) begin bad++;
            $display("FAIL sat_pulses: got %0d want 2", pulses_b); end
    endtask

    task automatic test_back_to_back();
        pulses_a = 0;
        vals_a.delete();
        bus_a.window_en = 1'b1;
        tick(25);
        total++; if (bus_a.busy !== 1'b1) begin bad++;
            $display("FAIL b2b_busy1: got %b want 1", bus_a.busy); end
        tick(25);
        bus_a.window_en = 1'b0;
        tick(1);
        bus_a.window_en = 1'b1;
        tick(15);
        total++; if (bus_a.busy !== 1'b1) begin bad++;
            $display("FAIL b2b_busy2: got %b want 1", bus_a.busy); end
        tick(15);
        bus_a.window_en = 1'b0;
        tick(8);
        total++; if (pulses_a !== 2) begin bad++;
            $display("FAIL b2b_pulses: got %0d want 2", pulses_a); end
        if (vals_a.size() == 2) begin
            total++; if (vals_a[0] !== 25'd50) begin bad++;
                $display("FAIL b2b_first: got %0d want 50", vals_a[0]); end
            total++; if (vals_a[1] !== 25'd30) begin bad++;
                $display("FAIL b2b_second: got %0d want 30", vals_a[1]); end
        end
    endtask

    task automatic test_reset_mid();
        pulses_a = 0;
        bus_a.window_en = 1'b1;
        tick(40);
        reset = 1'b1;
        #1;
        total++; if (bus_a.cut_count_end_val !== 25'd0) begin bad++;
            $display("FAIL rmid_end_val: got %0d want 0", bus_a.cut_count_end_val); end
        total++; if (bus_a.busy !== 1'b0) begin bad++;
            $display("FAIL rmid_busy: got %b want 0", bus_a.busy); end
        total++; if (bus_a.count_sat !== 1'b0) begin bad++;
            $display("FAIL rmid_sat: got %b want 0", bus_a.count_sat); end
        // Reset spans the remainder of the 100-cycle window.
        tick(60);
        bus_a.window_en = 1'b0;
        tick(1);
        reset = 1'b0;
        tick(10);
        total++; if (pulses_a !== 0) begin bad++;
            $display("FAIL rmid_pulses: got %0d want 0", pulses_a); end
        total++; if (bus_a.cut_count_end_val !== 25'd0) begin bad++;
            $display("FAIL rmid_after: got %0d want 0", bus_a.cut_count_end_val); end
    endtask

    task automatic test_short_and_quiet();
        int busy_seen;
        pulses_a = 0;
        vals_a.delete();
        bus_a.window_en = 1'b1;
        tick(1);
        bus_a.window_en = 1'b0;
        tick(6);
        total++; if (pulses_a !== 1) begin bad++;
            $display("FAIL short_pulses: got %0d want 1", pulses_a); end
        total++; if (bus_a.cut_count_end_val !== 25'd1) begin bad++;
            $display("FAIL short_value: got %0d want 1", bus_a.cut_count_end_val); end
        pulses_a  = 0;
        busy_seen = 0;
        for (int i = 0; i < 1000; i++) begin
            tick(1);
            if (bus_a.busy !== 1'b0) busy_seen++;
        end
        total++; if (pulses_a !== 0) begin bad++;
            $display("FAIL quiet_pulses: got %0d want 0", pulses_a); end
        total++; if (busy_seen !== 0) begin bad++;
            $display("FAIL quiet_busy: got %0d busy cycles want 0", busy_seen); end
    endtask

    task automatic test_release_high();
        pulses_a = 0;
        vals_a.delete();
        reset = 1'b1;
        bus_a.window_en = 1'b1;
        tick(3);
        reset = 1'b0;
        // Synchronised window closes 60 cycles after release.
        tick(60 - SYNC);
        bus_a.window_en = 1'b0;
        tick(3);
        total++; if (bus_a.end_val_valid !== 1'b1) begin bad++;
            $display("FAIL rel_valid: got %b want 1", bus_a.end_val_valid); end
        total++; if (bus_a.cut_count_end_val !== 25'(60 - SYNC)) begin bad++;
            $display("FAIL rel_value: got %0d want %0d", bus_a.cut_count_end_val, 60 - SYNC); end
        tick(5);
        total++; if (pulses_a !== 1) begin bad++;
            $display("FAIL rel_pulses: got %0d want 1", pulses_a); end
    endtask

    initial begin
        bus_a.window_en = 1'b0;
        bus_b.window_en = 1'b0;
        test_reset();
        test_window_100();
        test_saturate();
        test_back_to_back();
        test_reset_mid();
        test_short_and_quiet();
        test_release_high();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/esl_clk_check_cut_cnt.md
ESL_CLK_CHECK_CUT_CNT -- requirements
Module: esl_clk_check_cut_cnt

Interface
REQ-001 Parameter BIT_WD, default 24; end-value width is BIT_WD+1 bits.
REQ-002 Parameter SYNC_STAGES, default 2, legal range 2..4; depth of the window-enable synchroniser.
REQ-003 Port cut_clk, input, 1 bit; clock under test and the only clock; all flops clock on its rising edge.
REQ-004 Port reset, input, 1 bit; asynchronous, active-high reset.
REQ-005 Port window_en, input, 1 bit; test-phase window level from the reference-clock domain, asynchronous to cut_clk.
REQ-006 Port cut_count_end_val, output, BIT_WD+1 bits; cut_clk cycle count of the last completed window; feeds the frequency comparator.
REQ-007 Port end_val_valid, output, 1 bit; one-cycle pulse when cut_count_end_val updates.
REQ-008 Port count_sat, output, 1 bit; the last completed window saturated the counter.
REQ-009 Port busy, output, 1 bit; high while in state COUNT.

Function
REQ-010 window_en shall pass through a SYNC_STAGES-deep flop chain; the last stage is win_s; no other logic shall sample window_en.
REQ-011 The FSM shall have exactly three states: IDLE, COUNT, CAPTURE.
REQ-012 IDLE: cnt held at 0; win_s=1 -> COUNT with cnt loaded to 1; otherwise stay.
REQ-013 COUNT: win_s=1 -> cnt+1, saturating at all-ones, with internal sat flag set on the saturating cycle; win_s=0 -> CAPTURE, cnt unchanged.
REQ-014 CAPTURE, one cycle: cut_count_end_val<=cnt, count_sat<=sat, end_val_valid=1, sat cleared; win_s=1 -> COUNT with cnt=1 (back-to-back window); else IDLE with cnt=0.
REQ-015 Count semantics: cut_count_end_val equals the number of cut_clk cycles win_s was high (N-cycle window -> value N).
REQ-016 Latency: window_en fall to end_val_valid = SYNC_STAGES+1 cut_clk cycles.
REQ-017 Saturation: cnt never wraps; at 2^(BIT_WD+1)-1 it holds; count_sat reports 1 for that window only.
REQ-018 cut_count_end_val and count_sat hold between captures; only CAPTURE changes them.
REQ-019 end_val_valid is registered; high for exactly one cycle per completed window.
REQ-020 A window shorter than one cut_clk cycle that is missed by the synchroniser shall produce no capture; a captured value is always >=1.
REQ-021 cnt arithmetic is unsigned, BIT_WD+1 bits; no truncation at any stage.

Reset
REQ-022 Reset asserted: state=IDLE, cnt=0, sat=0, synchroniser flops=0, cut_count_end_val=0, end_val_valid=0, count_sat=0, busy=0, applied asynchronously.
REQ-023 Reset mid-COUNT shall discard the partial window: no end_val_valid and no update of cut_count_end_val.
REQ-024 After deassertion with window_en already high, counting begins after SYNC_STAGES cycles and yields a normal capture at window end.

Structure
REQ-025 Package esl_clk_check_pkg shall hold the state enum (IDLE, COUNT, CAPTURE) and the default BIT_WD and SYNC_STAGES constants shared with the comparator.
REQ-026 The synchroniser shall be a sub-module, esl_clk_check_sync, parameterised by SYNC_STAGES, with async reset to 0 and synthesis preserve attributes on its flops.
REQ-027 FSM, counter and output registers reside in esl_clk_check_cut_cnt.

Verification
REQ-028 window_en high for 100 cycles, then low -> exactly one end_val_valid, cut_count_end_val=100, count_sat=0, pulse 3 cycles after fall (SYNC_STAGES=2).
REQ-029 BIT_WD=3, window of 20 cycles -> cut_count_end_val=15, count_sat=1; next window of 5 cycles -> 5, count_sat=0.
REQ-030 Window 50 cycles, 1 cycle low, then window 30 cycles -> two pulses, values 50 then 30; busy high in both windows.
REQ-031 Reset pulsed at cycle 40 of a 100-cycle window -> no end_val_valid, cut_count_end_val stays 0, all outputs 0 during reset.
REQ-032 window_en high 1 cycle -> single capture value 1; window_en held low for 1000 cycles -> no end_val_valid, busy=0.
REQ-033 Reset released with window_en high, window ends 60 cycles later -> cut_count_end_val=60-SYNC_STAGES.
